// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file access sequencer.
//   RF_ADDR_W / RF_DATA_W : default register address / data widths (32 x 32 file)
//   state_e               : sequencer FSM states
//   ZERO_ADDR             : address of %g0
package regfile_pkg;

  localparam int unsigned RF_ADDR_W = 5;
  localparam int unsigned RF_DATA_W = 32;

  typedef enum logic [2:0] {
    StIdle,
    StRd1,
    StRd2,
    StCap,
    StDone
  } state_e;

  localparam logic [RF_ADDR_W-1:0] ZERO_ADDR = '0;

endpackage

// File: rtl/regfile_access_seq.sv
// Register-file access sequencer.
// Takes one operand/writeback request (rs1, rs2, rd, wr_en, wdata) and serialises it onto a
// single-port register file: read rs1, read rs2, then an optional write of rd. Both operands
// are returned on a valid/ready response four cycles after acceptance.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req_valid/req_ready, req_*     request channel (fields sampled only at acceptance)
//   rsp_valid/rsp_ready, rsp_op*   response channel (operands held stable while waiting)
//   reg_write, reg_adress,
//   data_write, data_read          register-file port (data_read is one cycle after address)
module regfile_access_seq
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W   = RF_ADDR_W,
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_rs1,
  input  logic [ADDR_W-1:0] req_rs2,
  input  logic [ADDR_W-1:0] req_rd,
  input  logic              req_wr_en,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_op1,
  output logic [DATA_W-1:0] rsp_op2,
  output logic              reg_write,
  output logic [ADDR_W-1:0] reg_adress,
  output logic [DATA_W-1:0] data_write,
  input  logic [DATA_W-1:0] data_read
);

  state_e state_q, state_d;

  logic [ADDR_W-1:0] rs1_q, rs2_q, rd_q;
  logic              wr_en_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] op1_q, op2_q;

  logic rs1_zero, rs2_zero, do_write;

  assign rs1_zero = ZERO_REG && (rs1_q == ADDR_W'(ZERO_ADDR));
  assign rs2_zero = ZERO_REG && (rs2_q == ADDR_W'(ZERO_ADDR));
  assign do_write = wr_en_q && !(ZERO_REG && (rd_q == ADDR_W'(ZERO_ADDR)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      wr_en_q <= 1'b0;
      wdata_q <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && req_valid) begin
        rs1_q   <= req_rs1;
        rs2_q   <= req_rs2;
        rd_q    <= req_rd;
        wr_en_q <= req_wr_en;
        wdata_q <= req_wdata;
      end
      // data_read lags the address by one cycle: rs1 data arrives in RD2, rs2 data in CAP.
      if (state_q == StRd2) op1_q <= rs1_zero ? '0 : data_read;
      if (state_q == StCap) op2_q <= rs2_zero ? '0 : data_read;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    reg_write  = 1'b0;
    reg_adress = '0;
    data_write = '0;
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) state_d = StRd1;
      end
      StRd1: begin
        reg_adress = rs1_q;
        state_d    = StRd2;
      end
      StRd2: begin
        reg_adress = rs2_q;
        state_d    = StCap;
      end
      StCap: begin
        reg_adress = rd_q;
        // Reset is the only input allowed to reach an output: it must suppress the write in
        // the very cycle it is sampled, otherwise the file would commit on the reset edge.
        if (do_write && !rst) begin
          reg_write  = 1'b1;
          data_write = wdata_q;
        end
        state_d = StDone;
      end
      StDone: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign rsp_op1 = op1_q;
  assign rsp_op2 = op2_q;

endmodule

// File: tb/tb_regfile_access_seq.sv
module tb_regfile_access_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [4:0]  req_rs1, req_rs2, req_rd;
  logic        req_wr_en;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_op1, rsp_op2;
  logic        reg_write;
  logic [4:0]  reg_adress;
  logic [31:0] data_write, data_read;

  // Preload port into the register-file model.
  logic        pl_en;
  logic [4:0]  pl_addr;
  logic [31:0] pl_data;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  regfile_access_seq dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .req_rd     (req_rd),
    .req_wr_en  (req_wr_en),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_op1    (rsp_op1),
    .rsp_op2    (rsp_op2),
    .reg_write  (reg_write),
    .reg_adress (reg_adress),
    .data_write (data_write),
    .data_read  (data_read)
  );

  // Single-port 32x32 register file with registered read data.
  logic [31:0] mem [32];
  always_ff @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (reg_write) mem[reg_adress] <= data_write;
    data_read <= mem[reg_adress];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // One full transaction, checking every cycle; hold = extra DONE cycles with rsp_ready low.
  task automatic txn(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                     input logic we, input logic [31:0] wd, input logic [31:0] e1,
                     input logic [31:0] e2, input logic ewr, input int hold);
    chk("idle_req_ready", req_ready, 1);
    req_rs1 = rs1; req_rs2 = rs2; req_rd = rd; req_wr_en = we; req_wdata = wd;
    req_valid = 1'b1;
    rsp_ready = (hold == 0);
    @(negedge clk);
    // Scramble fields after acceptance; the transaction must not notice.
    req_valid = 1'b0;
    req_rs1 = ~rs1; req_rs2 = ~rs2; req_rd = ~rd; req_wr_en = ~we; req_wdata = ~wd;
    chk("rd1_addr", reg_adress, rs1);
    chk("rd1_write", reg_write, 0);
    chk("rd1_req_ready", req_ready, 0);
    chk("rd1_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    chk("rd2_addr", reg_adress, rs2);
    chk("rd2_write", reg_write, 0);
    @(negedge clk);
    chk("cap_addr", reg_adress, rd);
    chk("cap_write", reg_write, ewr);
    chk("cap_wdata", data_write, ewr ? wd : 32'h0);
    chk("cap_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    chk("done_rsp_valid", rsp_valid, 1);
    chk("done_op1", rsp_op1, e1);
    chk("done_op2", rsp_op2, e2);
    chk("done_write", reg_write, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_op1", rsp_op1, e1);
      chk("hold_op2", rsp_op2, e2);
      chk("hold_req_ready", req_ready, 0);
      chk("hold_write", reg_write, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("after_rsp_valid", rsp_valid, 0);
    chk("after_req_ready", req_ready, 1);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
    req_rs1 = '0; req_rs2 = '0; req_rd = '0; req_wr_en = 1'b0; req_wdata = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_op1", rsp_op1, 0);
    chk("rst_op2", rsp_op2, 0);
    chk("rst_reg_write", reg_write, 0);
    chk("rst_reg_adress", reg_adress, 0);
    chk("rst_data_write", data_write, 0);
    rst = 1'b0;

    // r0 holds junk in the file so that forcing to zero is observable.
    preload(5'd0, 32'hAAAA_AAAA);
    preload(5'd5, 32'h1111_1111);
    preload(5'd6, 32'h2222_2222);
    preload(5'd7, 32'h0000_0005);
    preload(5'd9, 32'h0000_0003);

    // Plain read of two registers, no write.
    txn(5'd5, 5'd6, 5'd3, 1'b0, 32'h0, 32'h1111_1111, 32'h2222_2222, 1'b0, 0);
    // rd aliases both sources: operands are the pre-write value.
    txn(5'd7, 5'd7, 5'd7, 1'b1, 32'hDEAD_BEEF, 32'h5, 32'h5, 1'b1, 0);
    // Follow-up read sees the write; rs2=r0 is forced to zero.
    txn(5'd7, 5'd0, 5'd1, 1'b0, 32'h0, 32'hDEAD_BEEF, 32'h0, 1'b0, 0);
    // Write to r0 is discarded; rs1=r0 reads zero.
    txn(5'd0, 5'd5, 5'd0, 1'b1, 32'hFFFF_FFFF, 32'h0, 32'h1111_1111, 1'b0, 0);
    chk("r0_untouched", mem[0], 32'hAAAA_AAAA);
    txn(5'd0, 5'd0, 5'd2, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 0);
    // Consumer stalls for 10 cycles.
    txn(5'd6, 5'd5, 5'd4, 1'b0, 32'h0, 32'h2222_2222, 32'h1111_1111, 1'b0, 10);

    // Reset during CAP of a write to r9.
    req_rs1 = 5'd9; req_rs2 = 5'd9; req_rd = 5'd9; req_wr_en = 1'b1;
    req_wdata = 32'hCAFE_F00D; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rstcap_pre_write", reg_write, 1);
    rst = 1'b1;
    #1;
    chk("rstcap_write_blocked", reg_write, 0);
    @(negedge clk);
    rst = 1'b0;
    chk("rstcap_req_ready", req_ready, 1);
    chk("rstcap_rsp_valid", rsp_valid, 0);
    chk("rstcap_op1", rsp_op1, 0);
    chk("rstcap_r9", mem[9], 32'h3);
    txn(5'd9, 5'd9, 5'd0, 1'b0, 32'h0, 32'h3, 32'h3, 1'b0, 0);

    // Back-to-back with req_valid held high: second accepted 5 cycles after the first.
    req_rs1 = 5'd5; req_rs2 = 5'd6; req_rd = 5'd3; req_wr_en = 1'b0; req_wdata = 32'h0;
    req_valid = 1'b1;
    @(negedge clk);
    req_rs1 = 5'd6; req_rs2 = 5'd7; req_rd = 5'd10; req_wr_en = 1'b1;
    req_wdata = 32'h1234_5678;
    chk("b2b_a_rd1_addr", reg_adress, 5);
    repeat (3) @(negedge clk);
    chk("b2b_a_rsp_valid", rsp_valid, 1);
    chk("b2b_a_op1", rsp_op1, 32'h1111_1111);
    chk("b2b_a_op2", rsp_op2, 32'h2222_2222);
    @(negedge clk);
    chk("b2b_idle_ready", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b_b_rd1_addr", reg_adress, 6);
    chk("b2b_b_req_ready", req_ready, 0);
    repeat (2) @(negedge clk);
    chk("b2b_b_cap_write", reg_write, 1);
    chk("b2b_b_cap_addr", reg_adress, 10);
    @(negedge clk);
    chk("b2b_b_rsp_valid", rsp_valid, 1);
    chk("b2b_b_op1", rsp_op1, 32'h2222_2222);
    chk("b2b_b_op2", rsp_op2, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("b2b_end_ready", req_ready, 1);
    chk("b2b_r10", mem[10], 32'h1234_5678);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
